// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder
//
// Passive monitor for the multiplexed 7-segment display bus. It watches the
// active-low anode/cathode lines, waits for each digit dwell to settle,
// captures one sample per dwell and decodes the segment pattern back into BCD.
// It never drives the display.
//
// Optional build macro:
//   SEG_SYNC_EN - insert a 2-flop synchronizer on anode/cathode ahead of the
//                 input stage (for asynchronous or off-chip sources). Adds
//                 two cycles of latency. Undefined: inputs must be
//                 synchronous to clk.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (release synchronized to clk)
//   anode        active-low digit enables, bit i selects digit i
//   cathode      active-low segments, bit 7 = dp, bits 6:0 = g..a
//   digits       decoded BCD, digit i at [4i+3:4i]
//   dp           decimal point per digit, 1 = lit
//   digit_valid  1 = last capture of digit i was a legal pattern
//   frame_done   one-cycle pulse once every digit has been captured validly
//   err          one-cycle pulse on an illegal segment pattern capture
//   err_idx      digit index of the most recent err

module segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [7:0]              cathode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [2:0]              err_idx
);

  localparam logic [7:0] CNT_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state, state_next;
  logic [1:0]              rst_pipe;
  logic                    rst_core_n;
  logic [NUM_DIGITS-1:0]   anode_in, anode_s, anode_p;
  logic [7:0]              cathode_in, cathode_s, cathode_p;
  logic                    changed;
  logic [3:0]              low_count;
  logic [2:0]              low_idx;
  logic                    one_hot;
  logic [7:0]              settle_cnt;
  logic                    capture;
  logic [4:0]              dec;
  logic                    dec_ok;
  logic [3:0]              dec_val;
  logic [NUM_DIGITS-1:0]   mask, good_bits, mask_upd;
  logic                    mask_full;

  // Reset asserts immediately but releases only after two clean clock edges,
  // so no flop sees reset removal close to an active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_core_n = rst_pipe[1];

`ifdef SEG_SYNC_EN
  logic [NUM_DIGITS-1:0] anode_m1, anode_m2;
  logic [7:0]            cathode_m1, cathode_m2;

  // Resets to all-high so the synchronizer looks like a blank display.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      anode_m1   <= '1;
      anode_m2   <= '1;
      cathode_m1 <= '1;
      cathode_m2 <= '1;
    end else begin
      anode_m1   <= anode;
      anode_m2   <= anode_m1;
      cathode_m1 <= cathode;
      cathode_m2 <= cathode_m1;
    end
  end
  assign anode_in   = anode_m2;
  assign cathode_in = cathode_m2;
`else
  assign anode_in   = anode;
  assign cathode_in = cathode;
`endif

  // Current sample pair plus the previous pair, used to detect any change.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      anode_s   <= '1;
      cathode_s <= '1;
      anode_p   <= '1;
      cathode_p <= '1;
    end else begin
      anode_s   <= anode_in;
      cathode_s <= cathode_in;
      anode_p   <= anode_s;
      cathode_p <= cathode_s;
    end
  end

  assign changed = (anode_s != anode_p) || (cathode_s != cathode_p);

  // Count low anode bits; low_idx is meaningful only when exactly one is low.
  always_comb begin
    low_count = 4'd0;
    low_idx   = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anode_s[i]) begin
        low_count = low_count + 4'd1;
        low_idx   = 3'(i);
      end
    end
  end
  assign one_hot = (low_count == 4'd1);

  // Pattern table is the inverse of our encoder; 8 also accepts 7B,
  // which is the encoder's own rendering of 8.
  function automatic logic [4:0] decode_seg(input logic [6:0] lit);
    case (lit)
      7'h3F:        return {1'b1, 4'd0};
      7'h06:        return {1'b1, 4'd1};
      7'h5B:        return {1'b1, 4'd2};
      7'h4F:        return {1'b1, 4'd3};
      7'h66:        return {1'b1, 4'd4};
      7'h6D:        return {1'b1, 4'd5};
      7'h7D:        return {1'b1, 4'd6};
      7'h07:        return {1'b1, 4'd7};
      7'h7F, 7'h7B: return {1'b1, 4'd8};
      7'h6F:        return {1'b1, 4'd9};
      default:      return 5'd0;
    endcase
  endfunction

  assign dec     = decode_seg(~cathode_s[6:0]);
  assign dec_ok  = dec[4];
  assign dec_val = dec[3:0];

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) state <= IDLE;
    else             state <= state_next;
  end

  // One capture per dwell: SETTLE captures once the pair has been stable
  // long enough, HOLD then ignores the rest of the dwell.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) state_next = SETTLE;
      end
      SETTLE: begin
        if (changed) begin
          state_next = one_hot ? SETTLE : IDLE;
        end else if (one_hot && settle_cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (changed) state_next = one_hot ? SETTLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n)                     settle_cnt <= 8'd0;
    else if (state == IDLE || changed)   settle_cnt <= 8'd0;
    else if (settle_cnt != CNT_MAX)      settle_cnt <= settle_cnt + 8'd1;
  end

  // The mask clears in the same cycle it fills, so a capture landing in the
  // frame_done cycle starts the next frame.
  assign good_bits = (capture && dec_ok) ? ~anode_s : '0;
  assign mask_upd  = mask | good_bits;
  assign mask_full = &mask_upd;

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      digits      <= '0;
      dp          <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_idx     <= 3'd0;
      mask        <= '0;
    end else begin
      frame_done <= mask_full;
      err        <= capture && !dec_ok;
      mask       <= mask_full ? '0 : mask_upd;
      if (capture && !dec_ok) err_idx <= low_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && !anode_s[i]) begin
          digit_valid[i] <= dec_ok;
          if (dec_ok) begin
            digits[4*i +: 4] <= dec_val;
            dp[i]            <= ~cathode_s[7];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// tb_segment_scan_decoder
//
// Directed testbench for segment_scan_decoder (NUM_DIGITS=4, SETTLE_CYCLES=4).
// Each scenario task drives the display bus and checks outputs inline.

module tb_segment_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEG_SYNC_EN
  localparam int LAT = SC + 3;
`else
  localparam int LAT = SC + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] anode;
  logic [7:0]    cathode;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          err;
  logic [2:0]    err_idx;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fd_count     = 0;
  int err_count    = 0;
  int both_count   = 0;

  segment_scan_decoder #(
    .NUM_DIGITS(ND),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .anode(anode),
    .cathode(cathode),
    .digits(digits),
    .dp(dp),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .err(err),
    .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_count++;
      if (err) err_count++;
      if (frame_done && err) both_count++;
    end
  end

  // Hold a pair on the pins for n sampling edges; returns 1ns after an edge.
  task automatic dwell(input logic [ND-1:0] a, input logic [7:0] c, input int n);
    anode   = a;
    cathode = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_compared++; if (digits !== 16'h0) begin n_mismatched++; $display("[TB] FAIL reset_digits: got %h expected %h", digits, 16'h0); end
    n_compared++; if (dp !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_dp: got %b expected %b", dp, 4'h0); end
    n_compared++; if (digit_valid !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected %b", digit_valid, 4'h0); end
    n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    n_compared++; if (err_idx !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_err_idx: got %0d expected 0", err_idx); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] reset done");
  endtask

  task automatic test_scan;
    int fd0, e0;
    fd0 = fd_count;
    e0  = err_count;
    dwell(4'b1110, 8'hB0, 8);
    dwell(4'b1101, 8'hF9, 8);
    dwell(4'b1011, 8'h99, 8);
    dwell(4'b0111, 8'hF9, 8);
    dwell(4'b1111, 8'hFF, LAT + 3);
    n_compared++; if (digits !== 16'h1413) begin n_mismatched++; $display("[TB] FAIL scan_digits: got %h expected %h", digits, 16'h1413); end
    n_compared++; if (digit_valid !== 4'hF) begin n_mismatched++; $display("[TB] FAIL scan_valid: got %b expected %b", digit_valid, 4'hF); end
    n_compared++; if (dp !== 4'h0) begin n_mismatched++; $display("[TB] FAIL scan_dp: got %b expected %b", dp, 4'h0); end
    n_compared++; if (fd_count - fd0 !== 1) begin n_mismatched++; $display("[TB] FAIL scan_frame_done: got %0d pulses expected 1", fd_count - fd0); end
    n_compared++; if (err_count - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL scan_err: got %0d pulses expected 0", err_count - e0); end
  endtask

  task automatic test_loopback;
    int e0;
    e0 = err_count;
    anode   = 4'b1110;
    cathode = 8'h84;
    repeat (LAT) @(posedge clk);
    #1;
    n_compared++; if (digits[3:0] !== 4'd3) begin n_mismatched++; $display("[TB] FAIL loop_latency_early: got %h expected %h", digits[3:0], 4'd3); end
    @(posedge clk);
    #1;
    n_compared++; if (digits[3:0] !== 4'd8) begin n_mismatched++; $display("[TB] FAIL loop_latency_84: got %h expected %h", digits[3:0], 4'd8); end
    dwell(4'b1110, 8'h84, 2);
    dwell(4'b1111, 8'hFF, 2);
    dwell(4'b1110, 8'h80, 8);
    dwell(4'b1111, 8'hFF, LAT + 2);
    n_compared++; if (digits !== 16'h1418) begin n_mismatched++; $display("[TB] FAIL loop_80_digits: got %h expected %h", digits, 16'h1418); end
    n_compared++; if (dp[0] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loop_dp: got %b expected 0", dp[0]); end
    n_compared++; if (err_count - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL loop_err: got %0d pulses expected 0", err_count - e0); end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_count;
    dwell(4'b1110, 8'hC0, 3);
    anode   = 4'b1110;
    cathode = 8'hF9;
    repeat (LAT - 1) @(posedge clk);
    #1;
    // A capture of the 3-sample C0 dwell would already be visible here.
    n_compared++; if (digits[3:0] !== 4'd8) begin n_mismatched++; $display("[TB] FAIL glitch_no_capture: got %h expected %h", digits[3:0], 4'd8); end
    repeat (2) @(posedge clk);
    #1;
    n_compared++; if (digits[3:0] !== 4'd1) begin n_mismatched++; $display("[TB] FAIL glitch_capture: got %h expected %h", digits[3:0], 4'd1); end
    dwell(4'b1111, 8'hFF, LAT + 2);
    n_compared++; if (digits !== 16'h1411) begin n_mismatched++; $display("[TB] FAIL glitch_digits: got %h expected %h", digits, 16'h1411); end
    n_compared++; if (err_count - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL glitch_err: got %0d pulses expected 0", err_count - e0); end
  endtask

  task automatic test_illegal;
    int fd0, e0;
    fd0 = fd_count;
    e0  = err_count;
    dwell(4'b1110, 8'hC0, 8);
    dwell(4'b1101, 8'hA4, 8);
    dwell(4'b1011, 8'hFF, 8);
    dwell(4'b0111, 8'hB0, 8);
    dwell(4'b1111, 8'hFF, LAT + 3);
    n_compared++; if (err_count - e0 !== 1) begin n_mismatched++; $display("[TB] FAIL illegal_err_pulse: got %0d cycles expected 1", err_count - e0); end
    n_compared++; if (err_idx !== 3'd2) begin n_mismatched++; $display("[TB] FAIL illegal_err_idx: got %0d expected 2", err_idx); end
    n_compared++; if (digit_valid !== 4'b1011) begin n_mismatched++; $display("[TB] FAIL illegal_valid: got %b expected %b", digit_valid, 4'b1011); end
    n_compared++; if (digits !== 16'h3420) begin n_mismatched++; $display("[TB] FAIL illegal_digits: got %h expected %h", digits, 16'h3420); end
    n_compared++; if (fd_count - fd0 !== 0) begin n_mismatched++; $display("[TB] FAIL illegal_frame_done: got %0d pulses expected 0", fd_count - fd0); end
  endtask

  task automatic test_back_to_back;
    int fd0;
    fd0 = fd_count;
    dwell(4'b1011, 8'h92, 8);
    dwell(4'b1110, 8'hC0, 8);
    dwell(4'b1101, 8'hF9, 8);
    dwell(4'b1011, 8'h92, 8);
    dwell(4'b0111, 8'h99, 8);
    dwell(4'b1111, 8'hFF, LAT + 3);
    n_compared++; if (fd_count - fd0 !== 2) begin n_mismatched++; $display("[TB] FAIL b2b_frame_done: got %0d pulses expected 2", fd_count - fd0); end
    n_compared++; if (digits !== 16'h4510) begin n_mismatched++; $display("[TB] FAIL b2b_digits: got %h expected %h", digits, 16'h4510); end
    n_compared++; if (digit_valid !== 4'hF) begin n_mismatched++; $display("[TB] FAIL b2b_valid: got %b expected %b", digit_valid, 4'hF); end
  endtask

  task automatic test_ghost;
    int e0;
    e0 = err_count;
    dwell(4'b1100, 8'hB0, 10);
    dwell(4'b1111, 8'hB0, 10);
    dwell(4'b1111, 8'hFF, LAT + 2);
    n_compared++; if (digits !== 16'h4510) begin n_mismatched++; $display("[TB] FAIL ghost_digits: got %h expected %h", digits, 16'h4510); end
    n_compared++; if (err_count - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL ghost_err: got %0d pulses expected 0", err_count - e0); end
    dwell(4'b1110, 8'h40, 8);
    dwell(4'b1111, 8'hFF, LAT + 2);
    n_compared++; if (dp !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL dp_lit: got %b expected %b", dp, 4'b0001); end
    n_compared++; if (digits !== 16'h4510) begin n_mismatched++; $display("[TB] FAIL dp_digits: got %h expected %h", digits, 16'h4510); end
  endtask

  task automatic test_reset_mid;
    dwell(4'b1101, 8'hF9, 3);
    #2 rst_n = 1'b0;
    #1;
    n_compared++; if (digits !== 16'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_digits: got %h expected %h", digits, 16'h0); end
    n_compared++; if (dp !== 4'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_dp: got %b expected %b", dp, 4'h0); end
    n_compared++; if (digit_valid !== 4'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_valid: got %b expected %b", digit_valid, 4'h0); end
    n_compared++; if (err_idx !== 3'd0) begin n_mismatched++; $display("[TB] FAIL mid_reset_err_idx: got %0d expected 0", err_idx); end
    anode   = '1;
    cathode = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_compared++; if (digit_valid !== 4'h0) begin n_mismatched++; $display("[TB] FAIL post_reset_idle: got %b expected %b", digit_valid, 4'h0); end
    dwell(4'b1101, 8'hF9, 8);
    dwell(4'b1111, 8'hFF, LAT + 2);
    n_compared++; if (digits !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL post_reset_digits: got %h expected %h", digits, 16'h0010); end
    n_compared++; if (digit_valid !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL post_reset_valid: got %b expected %b", digit_valid, 4'b0010); end
  endtask

  task automatic test_exclusive;
    n_compared++; if (both_count !== 0) begin n_mismatched++; $display("[TB] FAIL frame_err_overlap: got %0d cycles expected 0", both_count); end
    n_compared++; if (err_count !== 1) begin n_mismatched++; $display("[TB] FAIL total_err: got %0d cycles expected 1", err_count); end
  endtask

  initial begin
    rst_n   = 1'b1;
    anode   = '1;
    cathode = 8'hFF;
    test_reset;
    test_scan;
    test_loopback;
    test_glitch;
    test_illegal;
    test_back_to_back;
    test_ghost;
    test_reset_mid;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
